// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes and FSM state encoding.
package mdu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd7;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: next {hi,lo} for the latched op and operands, plus divide-by-zero flag.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter bit ENABLE_MACC = 1'b1
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div0_o
);

  localparam int W2 = 2 * WIDTH;

  logic signed [W2-1:0] prod_s;
  logic [W2-1:0]        prod_u;
  logic [W2-1:0]        acc;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH-1:0]     q_mag;
  logic [WIDTH-1:0]     r_mag;
  logic [WIDTH-1:0]     q_s;
  logic [WIDTH-1:0]     r_s;

  assign acc    = {hi_i, lo_i};
  assign prod_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Divide by 1 instead of 0 so the dividers never produce X; the result is discarded anyway.
  assign div0_o  = (b_i == '0);
  assign divisor = div0_o ? WIDTH'(1) : b_i;

  // Signed divide on magnitudes: INT_MIN / -1 wraps back to INT_MIN with zero remainder.
  assign abs_a = a_i[WIDTH-1] ? -a_i : a_i;
  assign abs_b = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_mag = abs_a / abs_b;
  assign r_mag = abs_a % abs_b;
  assign q_s   = (a_i[WIDTH-1] ^ divisor[WIDTH-1]) ? -q_mag : q_mag;
  assign r_s   = a_i[WIDTH-1] ? -r_mag : r_mag;

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    case (op_i)
      OP_MULT:  {hi_o, lo_o} = prod_s;
      OP_MULTU: {hi_o, lo_o} = prod_u;
      OP_MADD:  if (ENABLE_MACC) {hi_o, lo_o} = acc + prod_s;
      OP_MSUB:  if (ENABLE_MACC) {hi_o, lo_o} = acc - prod_s;
      OP_DIV: begin
        if (!div0_o) begin
          hi_o = r_s;
          lo_o = q_s;
        end
      end
      OP_DIVU: begin
        if (!div0_o) begin
          hi_o = a_i % divisor;
          lo_o = a_i / divisor;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit: busy handshake FSM, cycle counter, operand latches and the HI/LO register pair.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter bit ENABLE_MACC = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] calc_hi, calc_lo;
  logic             calc_div0;

  mdu_calc #(
    .WIDTH       (WIDTH),
    .ENABLE_MACC (ENABLE_MACC)
  ) u_calc (
    .op_i   (op_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .hi_o   (calc_hi),
    .lo_o   (calc_lo),
    .div0_o (calc_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              state_d = ST_RUN;
              cnt_d   = CNT_W'(MULT_CYCLES);
              {op_d, a_d, b_d} = {md_op, a, b};
            end
            OP_MADD, OP_MSUB: begin
              if (ENABLE_MACC) begin
                state_d = ST_RUN;
                cnt_d   = CNT_W'(MULT_CYCLES);
                {op_d, a_d, b_d} = {md_op, a, b};
              end
            end
            OP_DIV, OP_DIVU: begin
              state_d = ST_RUN;
              cnt_d   = CNT_W'(DIV_CYCLES);
              {op_d, a_d, b_d} = {md_op, a, b};
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Flush wins over a completion landing on the same edge.
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!calc_div0 || !(op_q == OP_DIV || op_q == OP_DIVU)) begin
            hi_d = calc_hi;
            lo_d = calc_lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: reference model pushes expected {hi,lo}, compared when busy drops.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic [31:0] hi, lo, hi1, lo1;
  logic        busy, busy1;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb_q[$];
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always #5 clk = ~clk;

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .ENABLE_MACC(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy)
  );

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .ENABLE_MACC(1'b0)) dut_nomacc (
    .clk(clk), .reset(reset), .start(start1), .md_op(md_op), .a(a), .b(b),
    .flush(flush), .hi(hi1), .lo(lo1), .busy(busy1)
  );

  // Reference model: advances mhi/mlo as the DUT should.
  task automatic model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    longint sp;
    logic [63:0] acc;
    sp  = longint'($signed(av)) * longint'($signed(bv));
    acc = {mhi, mlo};
    case (op)
      OP_MULT:  {mhi, mlo} = sp;
      OP_MULTU: {mhi, mlo} = {32'd0, av} * {32'd0, bv};
      OP_MADD:  {mhi, mlo} = acc + sp;
      OP_MSUB:  {mhi, mlo} = acc - sp;
      OP_DIV: begin
        if (bv == 0) begin
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          mlo = 32'h8000_0000; mhi = 0;
        end else begin
          mlo = $signed(av) / $signed(bv);
          mhi = $signed(av) % $signed(bv);
        end
      end
      OP_DIVU: if (bv != 0) begin mlo = av / bv; mhi = av % bv; end
      OP_MTHI: mhi = av;
      OP_MTLO: mlo = av;
      default: ;
    endcase
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    model(op, av, bv);
    sb_q.push_back({mhi, mlo});
    @(negedge clk);
    md_op = op; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom; md_op = OP_NONE;
  endtask

  task automatic wait_done(input int ncyc, input string name);
    int cnt = 0;
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (!busy || cnt > 200) break;
      cnt++;
    end
    tests++;
    if (cnt !== ncyc) begin
      fails++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt, ncyc);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    tests++;
    if ({hi, lo} !== exp) begin
      fails++; $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input int ncyc, input string name);
    launch(op, av, bv);
    wait_done(ncyc, name);
  endtask

  task automatic move(input logic [3:0] op, input logic [31:0] v, input string name);
    model(op, v, 32'd0);
    @(negedge clk);
    md_op = op; a = v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; md_op = OP_NONE;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || hi !== mhi || lo !== mlo) begin
      fails++; $display("FAIL %s: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", name, busy, hi, lo, mhi, mlo);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      fails++; $display("FAIL reset_state: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5, "mult_neg");
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      fails++; $display("FAIL mult_const: got %h_%h expected ffffffff_ffffffeb", hi, lo);
    end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "multu_max");
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      fails++; $display("FAIL multu_const: got %h_%h expected fffffffe_00000001", hi, lo);
    end
  endtask

  task automatic test_div;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, "div_neg");
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      fails++; $display("FAIL div_const: got %h_%h expected ffffffff_fffffffd", hi, lo);
    end
    run_op(OP_DIVU, 32'd100, 32'd7, 10, "divu_100_7");
    tests++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      fails++; $display("FAIL divu_const: got hi=%0d lo=%0d expected hi=2 lo=14", hi, lo);
    end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_intmin");
    tests++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      fails++; $display("FAIL div_intmin_const: got hi=%h lo=%h expected 0 80000000", hi, lo);
    end
    move(OP_MTHI, 32'h0000_AAAA, "mthi_preset");
    move(OP_MTLO, 32'h0000_5555, "mtlo_preset");
    run_op(OP_DIV, 32'd1234, 32'd0, 10, "div_by_zero");
    tests++;
    if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
      fails++; $display("FAIL div0_const: got hi=%h lo=%h expected aaaa 5555", hi, lo);
    end
  endtask

  task automatic test_move_and_ignore;
    move(OP_MTHI, 32'h1234_5678, "mthi_idle");
    launch(OP_MULT, 32'd6, 32'd7);
    @(negedge clk);
    md_op = OP_MTLO; a = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    wait_done(3, "mult_mtlo_ignored");
  endtask

  task automatic test_macc;
    move(OP_MTLO, 32'h10, "mtlo_macc");
    move(OP_MTHI, 32'h0, "mthi_macc");
    run_op(OP_MADD, 32'd2, 32'd3, 5, "madd");
    tests++;
    if (lo !== 32'h16 || hi !== 32'h0) begin
      fails++; $display("FAIL madd_const: got hi=%h lo=%h expected 0 16", hi, lo);
    end
    run_op(OP_MSUB, 32'd1, 32'h17, 5, "msub");
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      fails++; $display("FAIL msub_const: got %h_%h expected all ones", hi, lo);
    end
    run_op(OP_MADD, 32'hFFFF_FFFF, 32'd1, 5, "madd_wrap");
  endtask

  task automatic test_nomacc;
    logic [31:0] h0, l0;
    h0 = hi1; l0 = lo1;
    @(negedge clk);
    md_op = OP_MADD; a = 32'd2; b = 32'd3; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0; md_op = OP_NONE;
    repeat (6) begin
      @(negedge clk);
      tests++;
      if (busy1 !== 1'b0 || hi1 !== h0 || lo1 !== l0) begin
        fails++; $display("FAIL nomacc_madd: busy=%b hi=%h lo=%h expected 0 %h %h", busy1, hi1, lo1, h0, l0);
      end
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    md_op = OP_MULT; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (6) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || hi !== mhi || lo !== mlo) begin
        fails++; $display("FAIL flush_mid: busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, mhi, mlo);
      end
    end
    @(negedge clk);
    md_op = OP_MTHI; a = 32'h5A5A_5A5A; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0; md_op = OP_NONE;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || hi !== mhi) begin
      fails++; $display("FAIL flush_start: busy=%b hi=%h expected 0 %h", busy, hi, mhi);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    md_op = OP_DIV; a = 32'd77; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      fails++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    mhi = '0; mlo = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op(OP_MULT, 32'd1000, 32'hFFFF_FFFE, 5, "mult_after_reset");
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops[6];
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB};
    for (int i = 0; i < 12; i++) begin
      logic [3:0] op;
      logic [31:0] av, bv;
      op = ops[$urandom_range(0, 5)];
      av = $urandom;
      bv = (i == 5) ? 32'd0 : $urandom;
      if (op == OP_DIV || op == OP_DIVU) begin
        if (i % 3 == 0) bv = bv & 32'hFF;
        run_op(op, av, bv, 10, "b2b_div");
      end else begin
        run_op(op, av, bv, 5, "b2b_mul");
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move_and_ignore();
    test_macc();
    test_nomacc();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
